sipo_deserializer: RTL and testbench
====================================

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port serial_in, input, 1 bit: serial data bit.
REQ-005 SHALL have port serial_valid, input, 1 bit: serial_in is sampled only on edges where this is 1.
REQ-006 SHALL have port frame_start, input, 1 bit: qualified by serial_valid; marks the current bit as bit 0 of a new word.
REQ-007 SHALL have port dir, input, 1 bit: 0 = MSB-first (shift left, new bit into [0]); 1 = LSB-first (shift right, new bit into [WIDTH-1]).
REQ-008 SHALL have port data_ready, input, 1 bit: consumer accepts parallel_data.
REQ-009 SHALL have port ovr_clear, input, 1 bit: synchronous clear of overrun.
REQ-010 SHALL have port parallel_data, output, WIDTH bits: last completed word, registered.
REQ-011 SHALL have port data_valid, output, 1 bit: parallel_data holds an unconsumed word.
REQ-012 SHALL have port busy, output, 1 bit: 1 while in SHIFT.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag; set when a completed word is dropped.

Function
REQ-014 SHALL implement FSM with states IDLE and SHIFT; busy = (state == SHIFT).
REQ-015 IDLE: on serial_valid && frame_start SHALL load the first bit, latch dir for the frame, set bit count to 1, and go to SHIFT; serial_valid without frame_start SHALL be ignored.
REQ-016 SHIFT: each serial_valid && !frame_start SHALL shift in one bit using the latched dir and increment the count; mid-frame dir changes SHALL be ignored.
REQ-017 SHIFT: serial_valid && frame_start SHALL discard the partial word and restart as in REQ-015 (count = 1, dir re-latched).
REQ-018 On the edge that samples bit WIDTH, the word SHALL be complete; the FSM SHALL return to IDLE on that same edge.
REQ-019 On completion, if data_valid is 0 or data_ready is 1, parallel_data SHALL load the completed word and data_valid SHALL be 1 on that same edge; latency is 0 cycles after the last bit edge.
REQ-020 On completion with data_valid = 1 and data_ready = 0, the new word SHALL be dropped, parallel_data SHALL hold, and overrun SHALL set.
REQ-021 data_valid SHALL clear on an edge with data_valid && data_ready and no simultaneous completion.
REQ-022 ovr_clear SHALL clear overrun unless a new overrun occurs on the same edge; set SHALL win.
REQ-023 Bit count register SHALL be $clog2(WIDTH+1) bits and SHALL never exceed WIDTH.
REQ-024 Cycles without serial_valid SHALL change no state other than handshake/flag updates, so gaps between bits are allowed.

Reset
REQ-025 reset low SHALL asynchronously force state = IDLE, shift register = 0, count = 0, parallel_data = 0, data_valid = 0, overrun = 0, and busy = 0, without waiting for a clk edge.
REQ-026 Reset asserted mid-frame SHALL discard the partial word; after release the block SHALL wait for frame_start.

Structure
REQ-027 Shared package sipo_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and the constants DIR_MSB_FIRST = 1'b0 and DIR_LSB_FIRST = 1'b1.
REQ-028 Shifting SHALL be in one sub-module, sipo_shift_core (WIDTH-bit register with load-first-bit/shift/dir controls); FSM, counter and output handshake SHALL stay in the top module.

Verification (WIDTH = 4)
REQ-029 MSB-first: dir=0, bits 1,0,1,1 on consecutive edges, frame_start on the first -> parallel_data = 4'b1011 and data_valid = 1 after the 4th edge, busy = 0.
REQ-030 LSB-first: dir=1, bits 1,0,1,1 -> parallel_data = 4'b1101; dir toggled mid-frame -> still 4'b1101.
REQ-031 Gaps and restart: bits 1,1 then 2 idle cycles, then frame_start with bits 0,0,1,0 (dir=0) -> parallel_data = 4'b0010 and the first two bits are discarded.
REQ-032 Overrun: data_ready=0, send 4'b1010 then 4'b0101 -> parallel_data stays 4'b1010 and overrun = 1; then ovr_clear=1 -> overrun = 0.
REQ-033 Simultaneous events: data_valid=1 with data_ready=1 on the completion edge of 4'b0110 -> parallel_data = 4'b0110, data_valid stays 1, overrun = 0.
REQ-034 Async reset: assert reset between clk edges after 2 bits -> all outputs 0 immediately; after release, a full frame 4'b1001 is received correctly.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out deserializer.
package sipo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit shift register. A first-bit load clears the word and places the
// bit at the entry end chosen by dir; a shift moves the word one place toward
// the far end. next_word exposes the value being written on this edge so the
// top level can capture a completed word without an extra cycle.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_first,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] next_word
);

  // Next register value; load_first takes priority over shift_en.
  always_comb begin
    next_word = word;
    if (load_first) begin
      next_word = '0;
      if (dir == DIR_MSB_FIRST) next_word[0] = bit_in;
      else                      next_word[WIDTH-1] = bit_in;
    end else if (shift_en) begin
      if (dir == DIR_MSB_FIRST) next_word = {word[WIDTH-2:0], bit_in};
      else                      next_word = {bit_in, word[WIDTH-1:1]};
    end
  end

  // Shift register storage, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) word <= '0;
    else        word <= next_word;
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with frame_start alignment, per-frame
// bit order, a valid/ready output holding register and a sticky overrun flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for serial_valid && frame_start; other bits ignored
// SHIFT | collecting bits 1..WIDTH-1 of the current frame
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  input  logic             dir,
  input  logic             data_ready,
  input  logic             ovr_clear,
  output logic [WIDTH-1:0] parallel_data,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             dir_lat;
  logic             load_first;
  logic             shift_en;
  logic             core_dir;
  logic             complete;
  logic [WIDTH-1:0] sr_word;
  logic [WIDTH-1:0] sr_next;

  // A frame_start restarts the frame from any state; plain bits only count in SHIFT.
  always_comb begin
    load_first = serial_valid && frame_start;
    shift_en   = serial_valid && !frame_start && (state == SHIFT);
    core_dir   = load_first ? dir : dir_lat;
    complete   = shift_en && (count == LAST_CNT);
  end

  sipo_shift_core #(
    .WIDTH(WIDTH)
  ) u_shift_core (
    .clk       (clk),
    .reset     (reset),
    .load_first(load_first),
    .shift_en  (shift_en),
    .dir       (core_dir),
    .bit_in    (serial_in),
    .word      (sr_word),
    .next_word (sr_next)
  );

  // Frame sequencing: state, bit count and the direction latched for the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      count   <= '0;
      dir_lat <= DIR_MSB_FIRST;
    end else if (load_first) begin
      state   <= SHIFT;
      busy    <= 1'b1;
      count   <= CNT_W'(1);
      dir_lat <= dir;
    end else if (complete) begin
      state <= IDLE;
      busy  <= 1'b0;
      count <= '0;
    end else if (shift_en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Output holding register and handshake; a word that cannot be stored is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parallel_data <= '0;
      data_valid    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (complete && (!data_valid || data_ready)) begin
        parallel_data <= sr_next;
        data_valid    <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (complete && data_valid && !data_ready) overrun <= 1'b1;
      else if (ovr_clear)                        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer at WIDTH = 4.
module tb_sipo_deserializer;

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic       serial_valid;
  logic       frame_start;
  logic       dir;
  logic       data_ready;
  logic       ovr_clear;
  logic [3:0] parallel_data;
  logic       data_valid;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  sipo_deserializer #(.WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .dir          (dir),
    .data_ready   (data_ready),
    .ovr_clear    (ovr_clear),
    .parallel_data(parallel_data),
    .data_valid   (data_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic fs, input logic b, input logic d,
                      input logic rdy, input logic clr);
    serial_valid = v;
    frame_start  = fs;
    serial_in    = b;
    dir          = d;
    data_ready   = rdy;
    ovr_clear    = clr;
    @(posedge clk);
    #1;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
    data_ready   = 1'b0;
    ovr_clear    = 1'b0;
  endtask

  // Four bits on consecutive edges, seq[3] first with frame_start.
  task automatic frame(input logic [3:0] seq, input logic d, input logic rdy_last,
                       input logic clr_last);
    step(1'b1, 1'b1, seq[3], d, 1'b0, 1'b0);
    step(1'b1, 1'b0, seq[2], d, 1'b0, 1'b0);
    step(1'b1, 1'b0, seq[1], d, 1'b0, 1'b0);
    step(1'b1, 1'b0, seq[0], d, rdy_last, clr_last);
  endtask

  initial begin
    reset        = 1'b1;
    serial_in    = 1'b0;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
    dir          = 1'b0;
    data_ready   = 1'b0;
    ovr_clear    = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_pd",   32'(parallel_data), 32'h0);
    check("rst_dv",   32'(data_valid),    32'h0);
    check("rst_busy", 32'(busy),          32'h0);
    check("rst_ovr",  32'(overrun),       32'h0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // Bits without frame_start are ignored in IDLE.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_ignore_busy", 32'(busy), 32'h0);

    // MSB-first 1,0,1,1.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("msb_busy_b1", 32'(busy), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("msb_dv_b3", 32'(data_valid), 32'h0);
    check("msb_busy_b3", 32'(busy), 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("msb_pd",   32'(parallel_data), 32'hB);
    check("msb_dv",   32'(data_valid),    32'h1);
    check("msb_busy", 32'(busy),          32'h0);
    check("msb_ovr",  32'(overrun),       32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("consume_dv", 32'(data_valid),    32'h0);
    check("consume_pd", 32'(parallel_data), 32'hB);

    // LSB-first 1,0,1,1 with dir toggling after the first bit.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lsb_pd", 32'(parallel_data), 32'hD);
    check("lsb_dv", 32'(data_valid),    32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Partial frame, idle gap, then restart: result 0010.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("gap_busy", 32'(busy),       32'h1);
    check("gap_dv",   32'(data_valid), 32'h0);
    frame(4'b0010, 1'b0, 1'b0, 1'b0);
    check("restart_pd", 32'(parallel_data), 32'h2);
    check("restart_dv", 32'(data_valid),    32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun: second word dropped while the first is unconsumed.
    frame(4'b1010, 1'b0, 1'b0, 1'b0);
    check("ovr_first_pd", 32'(parallel_data), 32'hA);
    check("ovr_first_flag", 32'(overrun), 32'h0);
    frame(4'b0101, 1'b0, 1'b0, 1'b0);
    check("ovr_pd",   32'(parallel_data), 32'hA);
    check("ovr_flag", 32'(overrun),       32'h1);
    check("ovr_dv",   32'(data_valid),    32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_clear", 32'(overrun),    32'h0);
    check("ovr_clr_dv", 32'(data_valid), 32'h1);

    // Completion with data_valid=1 and data_ready=1 on the same edge.
    frame(4'b0110, 1'b0, 1'b1, 1'b0);
    check("simul_pd",  32'(parallel_data), 32'h6);
    check("simul_dv",  32'(data_valid),    32'h1);
    check("simul_ovr", 32'(overrun),       32'h0);

    // Overrun set wins over a simultaneous ovr_clear.
    frame(4'b1111, 1'b0, 1'b0, 1'b1);
    check("setwin_ovr", 32'(overrun),       32'h1);
    check("setwin_pd",  32'(parallel_data), 32'h6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("setwin_clear", 32'(overrun), 32'h0);

    // Async reset two bits into a frame, between clock edges.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_pd",   32'(parallel_data), 32'h0);
    check("arst_dv",   32'(data_valid),    32'h0);
    check("arst_busy", 32'(busy),          32'h0);
    check("arst_ovr",  32'(overrun),       32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_busy", 32'(busy),       32'h0);
    check("post_rst_dv",   32'(data_valid), 32'h0);
    frame(4'b1001, 1'b0, 1'b0, 1'b0);
    check("post_rst_pd", 32'(parallel_data), 32'h9);
    check("post_rst_dv2", 32'(data_valid),   32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
